frame_pixel_packer: RTL
=======================

# frame_pixel_packer

Upstream feeder for the frame buffer write port. Accepts a stream of narrow pixels with a start-of-frame marker and packs them into 32-bit words. Drives an active-low write strobe with the packed word, in the form the frame buffer's `wr_en_in`/`data_in` expects. Tracks position within the frame and flags malformed frames.

## Interface
Parameters:
- `PIX_W`, 8, pixel width in bits.
- `WORD_W`, 32, output word width; must be an integer multiple of `PIX_W`. `PPW = WORD_W/PIX_W` (4 by default).
- `H_ACTIVE`, 640, pixels per line.
- `V_ACTIVE`, 480, lines per frame; `H_ACTIVE*V_ACTIVE` must be a multiple of `PPW`.
- `CNT_W`, 17, width of the word counter; must hold `H_ACTIVE*V_ACTIVE/PPW`.

Ports:
- `clk`, in, 1, single clock.
- `reset`, in, 1, asynchronous, active-low.
- `frame_start`, in, 1, qualifies the current `pix_valid` pixel as the first pixel of a frame.
- `pix_valid`, in, 1, a pixel is presented this cycle; always accepted, no backpressure.
- `pix_data`, in, `PIX_W`, pixel value.
- `err_clr`, in, 1, clears the sticky error flags.
- `wr_en_out`, out, 1, active-low write strobe to the frame buffer.
- `data_out`, out, `WORD_W`, packed word; valid while `wr_en_out`=0.
- `word_cnt`, out, `CNT_W`, number of words written in the current frame.
- `frame_done`, out, 1, one-cycle pulse coincident with the frame's last write strobe.
- `busy`, out, 1, high while in ACTIVE.
- `sof_err`, out, 1, sticky: `frame_start` arrived mid-frame.
- `stray_err`, out, 1, sticky: pixel arrived outside a frame.

## Operation
- Reset values: `wr_en_out`=1, `data_out`=0, `word_cnt`=0, `frame_done`=0, `busy`=0, `sof_err`=0, `stray_err`=0. State is IDLE and internal counters are 0.
- FSM has two states, IDLE and ACTIVE.
- IDLE:
  - `pix_valid & frame_start`: accept the pixel as pixel 0 and go to ACTIVE.
  - `pix_valid & !frame_start`: drop the pixel and set `stray_err`.
  - `frame_start` without `pix_valid`: ignored.
- ACTIVE, each `pix_valid` pixel:
  - Shifts into the pack register little-endian: pixel k of a word lands in bits `[k*PIX_W +: PIX_W]`.
  - The lane counter increments modulo `PPW`.
- When lane `PPW-1` is filled, the full word is issued and `word_cnt` increments.
- `frame_done` fires when the last word of the frame is issued (`word_cnt` reaches `H_ACTIVE*V_ACTIVE/PPW`). The FSM returns to IDLE. `word_cnt` holds its final value until the next frame is accepted, which resets it to 0.
- `frame_start` with `pix_valid` while in ACTIVE (short frame):
  - The partial word is discarded, with no write.
  - `sof_err` is set.
  - `word_cnt` is cleared and the pixel becomes pixel 0 of a new frame; the FSM stays in ACTIVE.
- `frame_start` without `pix_valid` in ACTIVE: ignored.
- Gaps (`pix_valid`=0) are allowed anywhere; the state is held.
- `err_clr` clears both error flags. If a new error occurs in the same cycle, setting wins.
- Asserting `reset` mid-frame aborts immediately to reset values; the partial word is lost.

## Timing
- Latency: the write strobe is registered. `wr_en_out` goes 0 in the cycle after the clock edge that accepts the final pixel of a word.
- `wr_en_out` is low for exactly one cycle per word.
- `data_out` updates only with a strobe and holds its value between strobes.
- `frame_done` and `word_cnt` update on the same edge as the strobe.
- Maximum throughput is one pixel per clock, giving one word every `PPW` clocks. Consecutive words are therefore never back-to-back strobes when `PPW`>1.
- A frame ending and a new `frame_start` pixel on the very next cycle is legal. The new frame is accepted because the FSM is already back in IDLE at that edge.
- `busy` rises on the edge that accepts pixel 0 and falls on the edge that issues the last word.

## Test plan
Use `H_ACTIVE`=4, `V_ACTIVE`=2 (8 pixels, 2 words) unless stated.
- Reset: hold `reset`=0 for 2 cycles with random inputs. Required: `wr_en_out`=1, `data_out`=0, `word_cnt`=0, `busy`=0, both error flags 0.
- Full frame: drive pixels 0x11,0x22,…,0x88 contiguously with `frame_start` on the first. Required:
  - Strobe 1 carries 0x44332211 and strobe 2 carries 0x88776655, each one cycle after the 4th/8th pixel.
  - `frame_done` pulses with strobe 2 and `word_cnt`=2.
- Gapped stream: insert idle cycles between every pixel of the same frame. Required: identical words and counts, and each strobe still lands one cycle after the completing pixel.
- Short frame: 3 pixels, then `frame_start` plus 8 new pixels. Required:
  - No write for the first partial word and `sof_err`=1.
  - The new frame produces 2 correct words.
  - `err_clr` returns `sof_err` to 0.
- Stray pixel: `pix_valid` without `frame_start` in IDLE. Required: `stray_err`=1 and no strobe.
- Back-to-back frames and mid-frame reset:
  - Start the next frame the cycle after `frame_done`. Required: 2+2 strobes with correct data.
  - Assert `reset` after 6 pixels. Required: outputs return to reset values and the following frame packs from lane 0.

Source files
------------

// File: rtl/frame_pixel_packer_if.sv
// Pixel-in / packed-word-out bundle between an upstream pixel source and the frame buffer feeder.
interface frame_pixel_packer_if #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 17
);
    logic              frame_start;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              err_clr;
    logic              wr_en_out;
    logic [WORD_W-1:0] data_out;
    logic [CNT_W-1:0]  word_cnt;
    logic              frame_done;
    logic              busy;
    logic              sof_err;
    logic              stray_err;

    modport master (
        output frame_start, pix_valid, pix_data, err_clr,
        input  wr_en_out, data_out, word_cnt, frame_done, busy, sof_err, stray_err
    );

    modport slave (
        input  frame_start, pix_valid, pix_data, err_clr,
        output wr_en_out, data_out, word_cnt, frame_done, busy, sof_err, stray_err
    );
endinterface

// File: rtl/frame_pixel_packer.sv
// Packs narrow pixels little-endian into words, strobes them out active-low,
// tracks the word position in the frame and flags malformed frames.
module frame_pixel_packer #(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned CNT_W    = 17
) (
    input logic                  clk,
    input logic                  reset,
    frame_pixel_packer_if.slave  bus
);
    localparam int unsigned PPW         = WORD_W / PIX_W;
    localparam int unsigned LANE_W      = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int unsigned FRAME_WORDS = (H_ACTIVE * V_ACTIVE) / PPW;

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e              state_q;
    logic [LANE_W-1:0]   lane_q;
    logic [WORD_W-1:0]   pack_q;
    logic [WORD_W-1:0]   data_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_en_q;
    logic                done_q;
    logic                busy_q;
    logic                sof_q;
    logic                stray_q;

    logic                accept_c;
    logic                restart_c;
    logic                sof_set_c;
    logic                stray_set_c;
    logic                last_lane_c;
    logic                last_word_c;
    logic [LANE_W-1:0]   lane_c;
    logic [CNT_W-1:0]    cnt_base_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic [WORD_W-1:0]   word_c;

    // A frame_start pixel restarts packing at lane 0 with a cleared word count.
    always_comb begin
        accept_c    = bus.pix_valid && ((state_q == ACTIVE) || bus.frame_start);
        restart_c   = accept_c && bus.frame_start;
        sof_set_c   = bus.pix_valid && bus.frame_start && (state_q == ACTIVE);
        stray_set_c = bus.pix_valid && !bus.frame_start && (state_q == IDLE);
        lane_c      = restart_c ? '0 : lane_q;
        cnt_base_c  = restart_c ? '0 : cnt_q;
        cnt_inc_c   = cnt_base_c + CNT_W'(1);
        word_c      = restart_c ? '0 : pack_q;
        for (int unsigned k = 0; k < PPW; k++) begin
            if (lane_c == LANE_W'(k)) begin
                word_c[k*PIX_W +: PIX_W] = bus.pix_data;
            end
        end
        last_lane_c = (lane_c == LANE_W'(PPW - 1));
        last_word_c = (cnt_inc_c == CNT_W'(FRAME_WORDS));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            pack_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            wr_en_q <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sof_q   <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b1;
            done_q  <= 1'b0;
            sof_q   <= sof_set_c   | (sof_q   & ~bus.err_clr);
            stray_q <= stray_set_c | (stray_q & ~bus.err_clr);
            if (accept_c) begin
                if (last_lane_c) begin
                    wr_en_q <= 1'b0;
                    data_q  <= word_c;
                    cnt_q   <= cnt_inc_c;
                    lane_q  <= '0;
                    if (last_word_c) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ACTIVE;
                        busy_q  <= 1'b1;
                    end
                end else begin
                    pack_q  <= word_c;
                    lane_q  <= lane_c + LANE_W'(1);
                    cnt_q   <= cnt_base_c;
                    state_q <= ACTIVE;
                    busy_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_en_out  = wr_en_q;
    assign bus.data_out   = data_q;
    assign bus.word_cnt   = cnt_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = busy_q;
    assign bus.sof_err    = sof_q;
    assign bus.stray_err  = stray_q;
endmodule
